// File: rtl/fetch_unit.sv
// RV32 IF stage: PC, single-outstanding imem handshake, one-entry decode buffer, redirect kill.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect raises a sticky flag and halts fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        fetch_misalign_o
);
    typedef enum logic [1:0] {REQ, WAIT, DROP, HALT} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic [31:0] redir_pc;
    logic        consume;
    logic        fire;
    logic        redir_take;
    logic        misalign_hit;

    assign consume          = inst_valid_o & ~stall_i;
    // Only request when the buffer will be free by the time the response lands.
    assign imem_req_valid_o = ~reset & (state == REQ) & (~inst_valid_o | consume);
    assign imem_addr_o      = pc_q;
    assign fire             = imem_req_valid_o & imem_req_ready_i;
    assign redir_take       = redirect_valid_i & (state != HALT);

`ifdef FETCH_MISALIGN_CHK_EN
    assign redir_pc     = redirect_pc_i;
    assign misalign_hit = redir_take & (redirect_pc_i[1:0] != 2'b00);
`else
    assign redir_pc     = {redirect_pc_i[31:2], 2'b00};
    assign misalign_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= REQ;
            pc_q             <= RESET_PC;
            req_pc_q         <= RESET_PC;
            inst_valid_o     <= 1'b0;
            inst_o           <= NOP_INST;
            inst_pc_o        <= RESET_PC;
            fetch_misalign_o <= 1'b0;
        end else begin
            if (consume) begin
                inst_valid_o <= 1'b0;
                inst_o       <= NOP_INST;
            end

            case (state)
                REQ: if (fire) begin
                    state    <= WAIT;
                    req_pc_q <= pc_q;
                    pc_q     <= pc_q + 32'd4;
                end
                WAIT: if (imem_resp_valid_i) begin
                    state        <= REQ;
                    inst_valid_o <= 1'b1;
                    inst_o       <= imem_resp_data_i;
                    inst_pc_o    <= req_pc_q;
                end
                DROP: if (imem_resp_valid_i) state <= REQ;
                HALT: ;
                default: state <= REQ;
            endcase

            // Redirect overrides everything above; an in-flight request becomes a DROP.
            if (misalign_hit) begin
                state            <= HALT;
                fetch_misalign_o <= 1'b1;
                inst_valid_o     <= 1'b0;
                inst_o           <= NOP_INST;
                inst_pc_o        <= redirect_pc_i;
            end else if (redir_take) begin
                pc_q         <= redir_pc;
                inst_valid_o <= 1'b0;
                inst_o       <= NOP_INST;
                case (state)
                    REQ:        state <= fire ? DROP : REQ;
                    WAIT, DROP: state <= imem_resp_valid_i ? REQ : DROP;
                    default:    ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: request-address queue and delivered-instruction queue,
// popped by independent monitors; imem model answers with programmable latency.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] OFS = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_ready_i = 1'b0;
    logic        imem_resp_valid_i = 1'b0;
    logic [31:0] imem_resp_data_i = '0;
    logic        imem_req_valid_o;
    logic [31:0] imem_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        fetch_misalign_o;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall_i(stall_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_addr_o(imem_addr_o), .imem_resp_valid_i(imem_resp_valid_i),
        .imem_resp_data_i(imem_resp_data_i), .inst_valid_o(inst_valid_o),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .fetch_misalign_o(fetch_misalign_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int lat = 1;
    int last_fire = -1;
    bit gap_en = 1'b0;
    logic [31:0] addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_dat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_inst(input logic [31:0] pc, input logic [31:0] dat);
        exp_pc_q.push_back(pc);
        exp_dat_q.push_back(dat);
    endtask

    // imem model: data word = address + OFS, returned lat cycles after accept.
    initial begin
        int cnt;
        bit f;
        logic [31:0] a, pa;
        cnt = 0; pa = '0;
        forever begin
            @(negedge clk);
            f = imem_req_valid_o && imem_req_ready_i;
            a = imem_addr_o;
            @(posedge clk);
            #1;
            imem_resp_valid_i = 1'b0;
            if (f) begin pa = a; cnt = lat; end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_resp_valid_i = 1'b1;
                    imem_resp_data_i  = pa + OFS;
                end
            end
        end
    end

    // Request monitor
    initial forever begin
        @(negedge clk);
        if (imem_req_valid_o && imem_req_ready_i) begin
            if (addr_q.size() == 0) check("unexpected_fire", imem_addr_o, 32'hxxxx_xxxx);
            else check("req_addr", imem_addr_o, addr_q.pop_front());
            if (gap_en && last_fire >= 0) check("fire_gap", cyc - last_fire, 2);
            last_fire = cyc;
        end
    end

    // Delivery monitor: one pop per instruction taken by decode
    initial forever begin
        @(negedge clk);
        if (inst_valid_o && !stall_i) begin
            if (exp_pc_q.size() == 0) check("unexpected_inst", inst_pc_o, 32'hxxxx_xxxx);
            else begin
                check("inst_pc", inst_pc_o, exp_pc_q.pop_front());
                check("inst_data", inst_o, exp_dat_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t reached, expected finish", $time);
        $fatal(1);
    end

    initial begin
        imem_req_ready_i = 1'b1;
        tick(2);
        @(negedge clk);
        check("rst_req_valid", imem_req_valid_o, 1'b0);
        check("rst_inst_valid", inst_valid_o, 1'b0);
        check("rst_inst", inst_o, NOP);
        check("rst_inst_pc", inst_pc_o, 32'h2000);
        check("rst_misalign", fetch_misalign_o, 1'b0);
        tick(1);

        // T1: streaming, 1-cycle imem
        addr_q.push_back(32'h2000); addr_q.push_back(32'h2004); addr_q.push_back(32'h2008);
        exp_inst(32'h2000, 32'h1000_2000);
        exp_inst(32'h2004, 32'h1000_2004);
        exp_inst(32'h2008, 32'h1000_2008);
        gap_en = 1'b1;
        reset = 1'b0;
        tick(5);
        imem_req_ready_i = 1'b0;
        gap_en = 1'b0;
        tick(3);

        // T3: backpressure holds request stable
        repeat (4) begin
            @(negedge clk);
            check("bp_req_valid", imem_req_valid_o, 1'b1);
            check("bp_addr", imem_addr_o, 32'h200C);
        end
        tick(1);

        // T2: stall holds the buffered instruction and blocks requests
        addr_q.push_back(32'h200C);
        exp_inst(32'h200C, 32'h1000_200C);
        imem_req_ready_i = 1'b1;
        stall_i = 1'b1;
        tick(2);
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", inst_valid_o, 1'b1);
            check("stall_pc", inst_pc_o, 32'h200C);
            check("stall_inst", inst_o, 32'h1000_200C);
            check("stall_no_req", imem_req_valid_o, 1'b0);
        end
        tick(1);
        stall_i = 1'b0;
        imem_req_ready_i = 1'b0;
        @(negedge clk);
        check("unstall_req", imem_req_valid_o, 1'b1);
        check("unstall_addr", imem_addr_o, 32'h2010);
        tick(1);

        // T4: redirect while waiting on a slow response
        addr_q.push_back(32'h2010);
        lat = 3;
        imem_req_ready_i = 1'b1;
        tick(1);
        imem_req_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h3000;
        tick(1);
        redirect_valid_i = 1'b0;
        @(negedge clk);
        check("t4_inst_valid", inst_valid_o, 1'b0);
        check("t4_drop_no_req", imem_req_valid_o, 1'b0);
        tick(3);
        @(negedge clk);
        check("t4_req_valid", imem_req_valid_o, 1'b1);
        check("t4_addr", imem_addr_o, 32'h3000);
        tick(1);
        addr_q.push_back(32'h3000);
        exp_inst(32'h3000, 32'h1000_3000);
        lat = 1;
        imem_req_ready_i = 1'b1;
        tick(1);
        imem_req_ready_i = 1'b0;
        tick(3);

        // T5a: redirect in the same cycle as the response
        addr_q.push_back(32'h3004);
        lat = 2;
        imem_req_ready_i = 1'b1;
        tick(1);
        imem_req_ready_i = 1'b0;
        tick(1);
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h4000;
        tick(1);
        redirect_valid_i = 1'b0;
        @(negedge clk);
        check("t5a_inst_valid", inst_valid_o, 1'b0);
        check("t5a_req_valid", imem_req_valid_o, 1'b1);
        check("t5a_addr", imem_addr_o, 32'h4000);
        tick(1);
        addr_q.push_back(32'h4000);
        exp_inst(32'h4000, 32'h1000_4000);
        lat = 1;
        imem_req_ready_i = 1'b1;
        tick(1);
        imem_req_ready_i = 1'b0;
        tick(3);

        // T5b: redirect in the same cycle as the request fires
        addr_q.push_back(32'h4004);
        imem_req_ready_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h4000;
        tick(1);
        imem_req_ready_i = 1'b0;
        redirect_valid_i = 1'b0;
        @(negedge clk);
        check("t5b_inst_valid", inst_valid_o, 1'b0);
        check("t5b_drop_no_req", imem_req_valid_o, 1'b0);
        tick(1);
        @(negedge clk);
        check("t5b_addr", imem_addr_o, 32'h4000);
        tick(1);
        addr_q.push_back(32'h4000);
        exp_inst(32'h4000, 32'h1000_4000);
        imem_req_ready_i = 1'b1;
        tick(1);
        imem_req_ready_i = 1'b0;
        tick(3);

        // T6: misaligned redirect
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h3002;
        tick(1);
        redirect_valid_i = 1'b0;
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
        check("mis_flag", fetch_misalign_o, 1'b1);
        check("mis_pc", inst_pc_o, 32'h3002);
        check("mis_inst_valid", inst_valid_o, 1'b0);
        tick(1);
        imem_req_ready_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h5000;
        repeat (3) begin
            @(negedge clk);
            check("halt_no_req", imem_req_valid_o, 1'b0);
            check("halt_sticky", fetch_misalign_o, 1'b1);
        end
        tick(1);
        redirect_valid_i = 1'b0;
        imem_req_ready_i = 1'b0;
`else
        check("mis_flag", fetch_misalign_o, 1'b0);
        check("mis_req_valid", imem_req_valid_o, 1'b1);
        check("mis_addr", imem_addr_o, 32'h3000);
        tick(1);
        addr_q.push_back(32'h3000);
        exp_inst(32'h3000, 32'h1000_3000);
        imem_req_ready_i = 1'b1;
        tick(1);
        imem_req_ready_i = 1'b0;
        tick(3);
        addr_q.push_back(32'h3004);
`endif

        // Reset mid-WAIT; the late stale response must be ignored
        lat = 3;
        imem_req_ready_i = 1'b1;
        tick(1);
        imem_req_ready_i = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_req", imem_req_valid_o, 1'b0);
        check("mid_rst_pc", inst_pc_o, 32'h2000);
        check("mid_rst_inst", inst_o, NOP);
        check("mid_rst_misalign", fetch_misalign_o, 1'b0);
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req", imem_req_valid_o, 1'b1);
        check("post_rst_addr", imem_addr_o, 32'h2000);
        tick(3);
        check("stale_ignored", inst_valid_o, 1'b0);
        addr_q.push_back(32'h2000);
        exp_inst(32'h2000, 32'h1000_2000);
        lat = 1;
        imem_req_ready_i = 1'b1;
        tick(1);
        imem_req_ready_i = 1'b0;
        tick(3);

        for (int i = 0; i < 20 && (addr_q.size() != 0 || exp_pc_q.size() != 0); i++) tick(1);
        check("addr_q_drained", addr_q.size(), 0);
        check("inst_q_drained", exp_pc_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
